// File: rtl/aes_inverse_cipher_iter_pkg.sv
// Shared AES definitions for the iterative inverse cipher: block/key types, round counts,
// GF(2^8) arithmetic, the inverse S-box and the engine FSM state type.
package aes_inverse_cipher_iter_pkg;

   typedef logic [127:0] state_t;
   typedef logic [127:0] roundKey_t;

   localparam int unsigned AES128_NR = 10;
   localparam int unsigned AES192_NR = 12;
   localparam int unsigned AES256_NR = 14;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Undo the S-box affine map, then invert in GF(2^8) as x^254 (0 maps to 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] x;
      logic [7:0] p;
      logic [7:0] r;
      x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
      p = x;
      r = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_inverse_cipher_iter_round_comb.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last_round, InvMixColumns. Byte i of state sits at bits [127-8i -: 8], i = row + 4*col.
module aes_inverse_round_comb
   import aes_inverse_cipher_iter_pkg::*;
(
   input  state_t    state,
   input  roundKey_t key,
   input  logic      last_round,
   output state_t    next_state
);

   logic [7:0] sb [16];
   logic [7:0] ak [16];
   logic [7:0] mc [16];

   always_comb begin
      sb         = '{default: '0};
      ak         = '{default: '0};
      mc         = '{default: '0};
      next_state = '0;
      // Row r of output column c comes from input column (c - r) mod 4.
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sb[r + 4*c] = inv_sbox(state[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
         end
      end
      for (int unsigned i = 0; i < 16; i++) begin
         ak[i] = sb[i] ^ key[127 - 8*i -: 8];
      end
      for (int unsigned c = 0; c < 4; c++) begin
         mc[4*c]   = gf_mul(ak[4*c], 8'h0e) ^ gf_mul(ak[4*c+1], 8'h0b)
                   ^ gf_mul(ak[4*c+2], 8'h0d) ^ gf_mul(ak[4*c+3], 8'h09);
         mc[4*c+1] = gf_mul(ak[4*c], 8'h09) ^ gf_mul(ak[4*c+1], 8'h0e)
                   ^ gf_mul(ak[4*c+2], 8'h0b) ^ gf_mul(ak[4*c+3], 8'h0d);
         mc[4*c+2] = gf_mul(ak[4*c], 8'h0d) ^ gf_mul(ak[4*c+1], 8'h09)
                   ^ gf_mul(ak[4*c+2], 8'h0e) ^ gf_mul(ak[4*c+3], 8'h0b);
         mc[4*c+3] = gf_mul(ak[4*c], 8'h0b) ^ gf_mul(ak[4*c+1], 8'h0d)
                   ^ gf_mul(ak[4*c+2], 8'h09) ^ gf_mul(ak[4*c+3], 8'h0e);
      end
      for (int unsigned i = 0; i < 16; i++) begin
         next_state[127 - 8*i -: 8] = last_round ? ak[i] : mc[i];
      end
   end

endmodule

// File: rtl/aes_inverse_cipher_iter.sv
// Iterative AES decryption engine, one inverse round per clock, keys fetched by index.
// Optional AES_INV_EARLY_ACCEPT_EN: accept the next block in DONE while the result is taken.
module aes_inverse_cipher_iter
   import aes_inverse_cipher_iter_pkg::*;
#(
   parameter int unsigned NR  = AES128_NR,
   parameter int unsigned RKW = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  state_t         in_data,
   output logic [RKW-1:0] rk_addr,
   input  roundKey_t      rk_data,
   output logic           out_valid,
   input  logic           out_ready,
   output state_t         out_data
);

   if (NR != AES128_NR && NR != AES192_NR && NR != AES256_NR) begin : g_bad_nr
      $error("aes_inverse_cipher_iter: NR must be 10, 12 or 14");
   end
   if ((2 ** RKW) <= NR) begin : g_bad_rkw
      $error("aes_inverse_cipher_iter: RKW too narrow to address round key NR");
   end

   localparam logic [RKW-1:0] ADDR_NR = RKW'(NR);
   localparam logic [RKW-1:0] ONE     = RKW'(1);

   fsm_t           fsm;
   logic [RKW-1:0] rnd;
   state_t         st;
   state_t         round_out;

   aes_inverse_round_comb u_round (
      .state      (st),
      .key        (rk_data),
      .last_round (fsm == FINAL),
      .next_state (round_out)
   );

`ifdef AES_INV_EARLY_ACCEPT_EN
   assign in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
`else
   assign in_ready = (fsm == IDLE);
`endif

   assign out_data = st;

   always_comb begin
      rk_addr = '0;
      case (fsm)
         IDLE:    rk_addr = ADDR_NR;
         ROUND:   rk_addr = rnd;
`ifdef AES_INV_EARLY_ACCEPT_EN
         DONE:    rk_addr = ADDR_NR;
`endif
         default: rk_addr = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm       <= IDLE;
         rnd       <= '0;
         st        <= '0;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  st  <= in_data ^ rk_data;
                  rnd <= ADDR_NR - ONE;
                  fsm <= ROUND;
               end
            end
            ROUND: begin
               st <= round_out;
               if (rnd == ONE) fsm <= FINAL;
               else            rnd <= rnd - ONE;
            end
            FINAL: begin
               st        <= round_out;
               out_valid <= 1'b1;
               fsm       <= DONE;
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  fsm       <= IDLE;
`ifdef AES_INV_EARLY_ACCEPT_EN
                  // in_ready equals out_ready here, so in_valid alone completes the input handshake.
                  if (in_valid) begin
                     st  <= in_data ^ rk_data;
                     rnd <= ADDR_NR - ONE;
                     fsm <= ROUND;
                  end
`endif
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
